// File: rtl/counter_read_seq.sv
// Burst reader: on a Start rising edge, reads DEPTH words from a sync-read buffer
// and hands each one to a valid/ready consumer, then pulses Done.
//
// state | meaning
// IDLE  | waiting for a Start rising edge
// READ  | issuing buffer reads and presenting words downstream
// DONE  | one-cycle Done pulse, Busy low, then back to IDLE
module counter_read_seq #(
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          Start,
  output logic          ReadEn,
  output logic [AW-1:0] ReadAddr,
  input  logic [DW-1:0] ReadData,
  output logic [DW-1:0] DataOut,
  output logic          DataValid,
  input  logic          DataReady,
  output logic          Busy,
  output logic          Done,
  output logic          Overrun
);

  typedef enum logic [1:0] {IDLE, READ, DONE} state_t;

  localparam logic [AW:0] DEPTH_IDX = (AW+1)'(DEPTH);

  state_t      state, state_nxt;
  logic [AW:0] idx;
  logic        pend;
  logic        start_d;
  logic        start_edge;
  logic        issue;
  logic        xfer;

  assign start_edge = Start & ~start_d;
  assign xfer       = DataValid & DataReady;
  // Only one read in flight, and only when the output slot is (or is about to be) free.
  assign issue      = (state == READ) & ~pend & (~DataValid | DataReady) & (idx < DEPTH_IDX);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ReadEn    = 1'b0;
    ReadAddr  = '0;
    Busy      = 1'b0;
    Done      = 1'b0;
    case (state)
      IDLE: if (start_edge) state_nxt = READ;
      READ: begin
        Busy   = 1'b1;
        ReadEn = issue;
        if (issue) ReadAddr = idx[AW-1:0];
        if ((idx == DEPTH_IDX) && !pend && xfer) state_nxt = DONE;
      end
      DONE: begin
        Done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx       <= '0;
      pend      <= 1'b0;
      start_d   <= 1'b0;
      DataOut   <= '0;
      DataValid <= 1'b0;
      Overrun   <= 1'b0;
    end else begin
      start_d <= Start;
      if (start_edge && (state != IDLE)) Overrun <= 1'b1;

      if ((state == IDLE) && start_edge) begin
        idx  <= '0;
        pend <= 1'b0;
      end else if (issue) begin
        idx  <= idx + 1'b1;
        pend <= 1'b1;
      end else if (pend) begin
        pend <= 1'b0;
      end

      // Data lands one cycle after the strobe; the slot is free by then.
      if (pend) begin
        DataOut   <= ReadData;
        DataValid <= 1'b1;
      end else if (xfer) begin
        DataValid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_counter_read_seq.sv
// Bench for counter_read_seq: buffer model, per-cycle monitor, and a queue of
// expected words pushed when each burst is started.
module tb_counter_read_seq;
  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int DW    = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          Start;
  logic          ReadEn;
  logic [AW-1:0] ReadAddr;
  logic [DW-1:0] ReadData = '0;
  logic [DW-1:0] DataOut;
  logic          DataValid;
  logic          DataReady;
  logic          Busy;
  logic          Done;
  logic          Overrun;

  counter_read_seq #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .Start(Start), .ReadEn(ReadEn), .ReadAddr(ReadAddr),
    .ReadData(ReadData), .DataOut(DataOut), .DataValid(DataValid),
    .DataReady(DataReady), .Busy(Busy), .Done(Done), .Overrun(Overrun)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) if (ReadEn) ReadData <= mem[ReadAddr];

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] got_q[$];
  int            addr_q[$];
  int done_cnt, busy_cnt, first_rd, stall_cnt, stab_err, rd_stall, bad_done, xfers, cyc;

  task automatic clear_mon();
    got_q.delete(); addr_q.delete();
    done_cnt = 0; busy_cnt = 0; first_rd = -1; stall_cnt = 0; stab_err = 0;
    rd_stall = 0; bad_done = 0; xfers = 0; cyc = 0;
  endtask

  task automatic start_burst();
    exp_q.delete();
    for (int i = 0; i < DEPTH; i++) exp_q.push_back(mem[i]);
    Start = 1'b1;
  endtask

  // Drives DataReady and records what the DUT does each cycle.
  task automatic run_cycles(input int n, input int stop_xfers, input int stall_word, input int stall_len);
    logic          held_vld;
    logic [DW-1:0] held_val;
    held_vld = 1'b0;
    held_val = '0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      DataReady = !(DataValid && (xfers == stall_word) && (stall_cnt < stall_len));
      #1;
      if (held_vld && (!DataValid || DataOut !== held_val)) stab_err++;
      if (ReadEn) begin
        addr_q.push_back(int'(ReadAddr));
        if (first_rd < 0) first_rd = cyc;
      end
      if (DataValid && !DataReady) begin
        stall_cnt++;
        if (ReadEn) rd_stall++;
      end
      if (DataValid && DataReady) begin
        got_q.push_back(DataOut);
        xfers++;
      end
      if (Done) begin
        done_cnt++;
        if (Busy) bad_done++;
      end
      if (Busy) busy_cnt++;
      held_vld = DataValid && !DataReady;
      held_val = DataOut;
      cyc++;
      if (stop_xfers > 0 && xfers >= stop_xfers) break;
    end
  endtask

  task automatic test_reset();
    logic [DW+AW+4:0] outs;
    rst = 1'b1; Start = 1'b0; DataReady = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    checks++; if (ReadEn !== 1'b0)    begin errors++; $display("FAIL reset_readen got %b expected 0", ReadEn); end
    checks++; if (ReadAddr !== '0)    begin errors++; $display("FAIL reset_readaddr got %0h expected 0", ReadAddr); end
    checks++; if (DataOut !== '0)     begin errors++; $display("FAIL reset_dataout got %0h expected 0", DataOut); end
    checks++; if (DataValid !== 1'b0) begin errors++; $display("FAIL reset_datavalid got %b expected 0", DataValid); end
    checks++; if (Busy !== 1'b0)      begin errors++; $display("FAIL reset_busy got %b expected 0", Busy); end
    checks++; if (Done !== 1'b0)      begin errors++; $display("FAIL reset_done got %b expected 0", Done); end
    checks++; if (Overrun !== 1'b0)   begin errors++; $display("FAIL reset_overrun got %b expected 0", Overrun); end
    rst = 1'b0;
    clear_mon();
    run_cycles(5, 0, -1, 0);
    outs = {ReadEn, ReadAddr, DataOut, DataValid, Busy, Done, Overrun};
    checks++; if (addr_q.size() != 0 || done_cnt != 0 || outs !== '0)
      begin errors++; $display("FAIL idle_quiet reads %0d done %0d outs %0h expected 0 0 0", addr_q.size(), done_cnt, outs); end
  endtask

  task automatic test_basic();
    logic [DW-1:0] e, g;
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'h10 + 8'(i);
    clear_mon();
    start_burst();
    run_cycles(40, 0, -1, 0);
    checks++; if (addr_q.size() != DEPTH) begin errors++; $display("FAIL basic_nreads got %0d expected %0d", addr_q.size(), DEPTH); end
    for (int i = 0; i < addr_q.size(); i++) begin
      checks++; if (addr_q[i] !== i) begin errors++; $display("FAIL basic_addr[%0d] got %0d expected %0d", i, addr_q[i], i); end
    end
    checks++; if (got_q.size() != DEPTH) begin errors++; $display("FAIL basic_nwords got %0d expected %0d", got_q.size(), DEPTH); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      checks++; if (g !== e) begin errors++; $display("FAIL basic_data got %0h expected %0h", g, e); end
    end
    checks++; if (first_rd !== 0) begin errors++; $display("FAIL basic_first_read cycle got %0d expected 0", first_rd); end
    checks++; if (done_cnt != 1 || bad_done != 0) begin errors++; $display("FAIL basic_done cycles %0d busy_overlap %0d expected 1 0", done_cnt, bad_done); end
    checks++; if (busy_cnt != 2*DEPTH+1) begin errors++; $display("FAIL basic_busy_len got %0d expected %0d", busy_cnt, 2*DEPTH+1); end
    checks++; if (Busy !== 1'b0 || Overrun !== 1'b0) begin errors++; $display("FAIL basic_end busy %b overrun %b expected 0 0", Busy, Overrun); end
  endtask

  task automatic test_hold();
    clear_mon();
    run_cycles(100, 0, -1, 0);
    checks++; if (addr_q.size() != 0 || done_cnt != 0) begin errors++; $display("FAIL hold_retrigger reads %0d done %0d expected 0 0", addr_q.size(), done_cnt); end
    checks++; if (Overrun !== 1'b0) begin errors++; $display("FAIL hold_overrun got %b expected 0", Overrun); end
    Start = 1'b0;
    run_cycles(2, 0, -1, 0);
  endtask

  task automatic test_stall();
    logic [DW-1:0] e, g;
    clear_mon();
    start_burst();
    run_cycles(45, 0, 3, 5);
    Start = 1'b0;
    checks++; if (stall_cnt != 5) begin errors++; $display("FAIL stall_len got %0d expected 5", stall_cnt); end
    checks++; if (stab_err != 0) begin errors++; $display("FAIL stall_stable changes %0d expected 0", stab_err); end
    checks++; if (rd_stall != 0) begin errors++; $display("FAIL stall_readen reads %0d expected 0", rd_stall); end
    checks++; if (got_q.size() != DEPTH || addr_q.size() != DEPTH)
      begin errors++; $display("FAIL stall_count words %0d reads %0d expected %0d", got_q.size(), addr_q.size(), DEPTH); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      checks++; if (g !== e) begin errors++; $display("FAIL stall_data got %0h expected %0h", g, e); end
    end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL stall_done got %0d expected 1", done_cnt); end
    run_cycles(2, 0, -1, 0);
  endtask

  task automatic test_overrun();
    logic [DW-1:0] e, g;
    clear_mon();
    start_burst();
    run_cycles(4, 0, -1, 0);
    Start = 1'b0;
    run_cycles(2, 0, -1, 0);
    Start = 1'b1;
    run_cycles(40, 0, -1, 0);
    Start = 1'b0;
    run_cycles(3, 0, -1, 0);
    checks++; if (Overrun !== 1'b1) begin errors++; $display("FAIL overrun_sticky got %b expected 1", Overrun); end
    checks++; if (got_q.size() != DEPTH || done_cnt != 1)
      begin errors++; $display("FAIL overrun_burst words %0d done %0d expected %0d 1", got_q.size(), done_cnt, DEPTH); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      checks++; if (g !== e) begin errors++; $display("FAIL overrun_data got %0h expected %0h", g, e); end
    end
    for (int i = 0; i < addr_q.size(); i++) begin
      checks++; if (addr_q[i] !== i) begin errors++; $display("FAIL overrun_addr[%0d] got %0d expected %0d", i, addr_q[i], i); end
    end
  endtask

  task automatic test_mid_reset();
    logic [DW-1:0] e, g;
    logic [DW+AW+4:0] outs;
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'hA0 + 8'(3*i);
    clear_mon();
    start_burst();
    run_cycles(40, 5, -1, 0);
    checks++; if (xfers != 5) begin errors++; $display("FAIL midrst_reach got %0d words expected 5", xfers); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      checks++; if (g !== e) begin errors++; $display("FAIL midrst_data got %0h expected %0h", g, e); end
    end
    @(negedge clk);
    rst = 1'b1; Start = 1'b0;
    @(negedge clk); #1;
    outs = {ReadEn, ReadAddr, DataOut, DataValid, Busy, Done, Overrun};
    checks++; if (outs !== '0) begin errors++; $display("FAIL midrst_outputs got %0h expected 0", outs); end
    rst = 1'b0;
    clear_mon();
    run_cycles(10, 0, -1, 0);
    checks++; if (done_cnt != 0 || addr_q.size() != 0) begin errors++; $display("FAIL midrst_no_done done %0d reads %0d expected 0 0", done_cnt, addr_q.size()); end
    clear_mon();
    start_burst();
    run_cycles(40, 0, -1, 0);
    Start = 1'b0;
    checks++; if (addr_q.size() != DEPTH || done_cnt != 1)
      begin errors++; $display("FAIL midrst_fresh reads %0d done %0d expected %0d 1", addr_q.size(), done_cnt, DEPTH); end
    for (int i = 0; i < addr_q.size(); i++) begin
      checks++; if (addr_q[i] !== i) begin errors++; $display("FAIL midrst_addr[%0d] got %0d expected %0d", i, addr_q[i], i); end
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      checks++; if (g !== e) begin errors++; $display("FAIL midrst_fresh_data got %0h expected %0h", g, e); end
    end
    run_cycles(2, 0, -1, 0);
  endtask

  task automatic test_start_at_reset();
    logic [DW-1:0] e, g;
    @(negedge clk);
    rst = 1'b1;
    start_burst();
    @(negedge clk);
    @(negedge clk); #1;
    rst = 1'b0;
    clear_mon();
    run_cycles(40, 0, -1, 0);
    Start = 1'b0;
    checks++; if (first_rd !== 0) begin errors++; $display("FAIL rststart_first_read cycle got %0d expected 0", first_rd); end
    checks++; if (addr_q.size() != DEPTH || got_q.size() != DEPTH || done_cnt != 1)
      begin errors++; $display("FAIL rststart_burst reads %0d words %0d done %0d expected %0d %0d 1", addr_q.size(), got_q.size(), done_cnt, DEPTH, DEPTH); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      checks++; if (g !== e) begin errors++; $display("FAIL rststart_data got %0h expected %0h", g, e); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_stall();
    test_overrun();
    test_mid_reset();
    test_start_at_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout after %0d checks", checks);
    $fatal(1, "timeout");
  end

endmodule
